rom_scan_reader: RTL

Parametrised successor to the single-address ROM reader, for 556PT5 (3604, 512x8) and 556PT4 (3601, 256x4) PROMs.
- Drives address and operation code (V1..V4), waits a programmable settle time, then captures chip data.
- Presents each captured word with its address on a valid/ready output port; the top level feeds this port to a transfer or display block.
- Two modes: auto-scan of the whole ROM, and step mode (manual increment/decrement re-read).

---
 rtl/rom_scan_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rom_scan_reader.sv
// ROM scan reader for 556PT5 / 556PT4 style PROMs.
// Drives address and V1..V4 operation code, waits a programmable settle
// time, captures chip data and offers it on a valid/ready port. Supports a
// full auto-scan and a step mode (re-read / increment / decrement).
module rom_scan_reader #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDRESS_WIDTH  = 9,
    parameter int unsigned ROM_DEPTH      = 512,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter logic [3:0]  READ_OPERATION = 4'b1100,
    parameter logic [3:0]  IDLE_OPERATION = 4'b0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mode,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     increment_address,
    input  logic                     decrement_address,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    data_line,
    output logic [ADDRESS_WIDTH-1:0] data_address,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(ROM_DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD,
        ST_NEXT
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            cnt_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [3:0]               op_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [ADDRESS_WIDTH-1:0] daddr_q;
    logic                     valid_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     step_q;   // mode latched when leaving IDLE

    // Candidate next addresses, wrapping modulo ROM_DEPTH rather than 2**ADDRESS_WIDTH.
    logic [ADDRESS_WIDTH-1:0] addr_inc_d;
    logic [ADDRESS_WIDTH-1:0] addr_dec_d;

    // Modulo-ROM_DEPTH increment/decrement of the current chip address.
    always_comb begin
        addr_inc_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
        addr_dec_d = (addr_q == '0) ? LAST_ADDR : addr_q - ADDR_ONE;
    end

    // Scan FSM with registered chip-side and consumer-side outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            op_q    <= IDLE_OPERATION;
            data_q  <= '0;
            daddr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                op_q    <= IDLE_OPERATION;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        op_q <= IDLE_OPERATION;
                        if (start) begin
                            step_q  <= mode;
                            if (!mode) begin
                                addr_q <= '0;
                            end
                            op_q    <= READ_OPERATION;
                            busy_q  <= 1'b1;
                            state_q <= ST_SETUP;
                        end else if (mode && (increment_address ^ decrement_address)) begin
                            step_q  <= 1'b1;
                            addr_q  <= increment_address ? addr_inc_d : addr_dec_d;
                            op_q    <= READ_OPERATION;
                            busy_q  <= 1'b1;
                            state_q <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (cnt_q == CNT_ONE) begin
                            state_q <= ST_CAPTURE;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    ST_CAPTURE: begin
                        data_q  <= data_line_in;
                        daddr_q <= addr_q;
                        valid_q <= 1'b1;
                        op_q    <= IDLE_OPERATION;
                        state_q <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (data_ready) begin
                            valid_q <= 1'b0;
                            if (step_q) begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_NEXT;
                            end
                        end
                    end
                    ST_NEXT: begin
                        if (addr_q == LAST_ADDR) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            addr_q  <= addr_inc_d;
                            op_q    <= READ_OPERATION;
                            state_q <= ST_SETUP;
                        end
                    end
                    default: begin
                        op_q    <= IDLE_OPERATION;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign operation    = op_q;
    assign address_line = addr_q;
    assign data_line    = data_q;
    assign data_address = daddr_q;
    assign data_valid   = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
